// File: rtl/ccip_rd_client_mux_if.sv
// Bus bundle for ccip_rd_client_mux: the client-side c0 read request/response
// signals and the FIU-side (MPF "afu" port) read request/response signals.
//
// Handshake: a client request is transferred in a cycle where
// cl_rd_valid[i] & cl_rd_ready[i] are both 1. cl_rd_ready is a combinational
// one-hot grant and never depends on a client's own ready. The FIU side has
// no ready: fiu_rd_valid and fiu_rsp_valid are single-cycle pulses, and
// fiu_almfull is the only back-pressure signal.
//
// slave  : the mux itself
// master : the environment driving clients and modelling MPF
interface ccip_rd_client_mux_if #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 42,
  parameter int MDATA_W   = 16,
  parameter int DATA_W    = 512
) ();
  localparam int TAG_W   = $clog2(N_CLIENTS);
  localparam int CL_MD_W = MDATA_W - TAG_W;

  // client request side
  logic [N_CLIENTS-1:0]         cl_rd_valid;
  logic [N_CLIENTS*ADDR_W-1:0]  cl_rd_addr;
  logic [N_CLIENTS*CL_MD_W-1:0] cl_rd_mdata;
  logic [N_CLIENTS-1:0]         cl_rd_ready;

  // FIU request side
  logic                         fiu_rd_valid;
  logic [ADDR_W-1:0]            fiu_rd_addr;
  logic [MDATA_W-1:0]           fiu_rd_mdata;
  logic                         fiu_almfull;

  // FIU response side
  logic                         fiu_rsp_valid;
  logic [MDATA_W-1:0]           fiu_rsp_mdata;
  logic [DATA_W-1:0]            fiu_rsp_data;

  // client response side
  logic [N_CLIENTS-1:0]         cl_rsp_valid;
  logic [CL_MD_W-1:0]           cl_rsp_mdata;
  logic [DATA_W-1:0]            cl_rsp_data;

  modport slave (
    input  cl_rd_valid, cl_rd_addr, cl_rd_mdata,
    output cl_rd_ready,
    output fiu_rd_valid, fiu_rd_addr, fiu_rd_mdata,
    input  fiu_almfull,
    input  fiu_rsp_valid, fiu_rsp_mdata, fiu_rsp_data,
    output cl_rsp_valid, cl_rsp_mdata, cl_rsp_data
  );

  modport master (
    output cl_rd_valid, cl_rd_addr, cl_rd_mdata,
    input  cl_rd_ready,
    input  fiu_rd_valid, fiu_rd_addr, fiu_rd_mdata,
    output fiu_almfull,
    output fiu_rsp_valid, fiu_rsp_mdata, fiu_rsp_data,
    input  cl_rsp_valid, cl_rsp_mdata, cl_rsp_data
  );
endinterface

// File: rtl/ccip_rd_client_mux.sv
// ccip_rd_client_mux: N-client round-robin mux for CCI-P c0 read requests.
// Tags the top mdata bits with the client index, enforces per-client
// outstanding-read credits, routes responses back by tag, and offers a drain
// FSM (RUN -> DRAIN -> DRAINED) for quiescing before reset/PR.
//
// Optional feature macro: CCIP_RD_MUX_STATS_EN adds stat_grants and
// stat_almfull_cyc counters. Default build (macro undefined) omits them.
module ccip_rd_client_mux #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 42,
  parameter int MDATA_W   = 16,
  parameter int DATA_W    = 512,
  parameter int MAX_OUT   = 32
) (
  input  logic                   pClk,
  input  logic                   SoftReset_n,
  ccip_rd_client_mux_if.slave    bus,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   err_sticky,
`ifdef CCIP_RD_MUX_STATS_EN
  output logic [N_CLIENTS*32-1:0] stat_grants,
  output logic [31:0]             stat_almfull_cyc,
`endif
  output logic [1:0]             fsm_state
);
  localparam int TAG_W   = $clog2(N_CLIENTS);
  localparam int CL_MD_W = MDATA_W - TAG_W;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_CLIENTS - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [TAG_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     cnt [N_CLIENTS];
  logic [N_CLIENTS-1:0] eligible;
  logic [N_CLIENTS-1:0] grant_vec;
  logic [TAG_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 accept;
  logic [N_CLIENTS-1:0] inc_vec;
  logic [N_CLIENTS-1:0] dec_vec;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 tag_ok;
  logic                 rsp_hit;
  logic                 all_zero;

  assign fsm_state  = state;
  assign drain_done = (state == DRAINED);

  assign rsp_tag = bus.fiu_rsp_mdata[MDATA_W-1 -: TAG_W];

  // With a power-of-two client count every tag value names a real client.
  generate
    if ((2 ** TAG_W) == N_CLIENTS) begin : g_tag_full
      assign tag_ok = 1'b1;
    end else begin : g_tag_partial
      assign tag_ok = (rsp_tag < TAG_W'(N_CLIENTS));
    end
  endgenerate

  assign rsp_hit = bus.fiu_rsp_valid & tag_ok;

  // Eligibility per client and the all-credits-returned condition for draining.
  always_comb begin
    eligible = '0;
    all_zero = 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      eligible[i] = bus.cl_rd_valid[i] & (cnt[i] < MAX_CNT) &
                    ~bus.fiu_almfull & (state == RUN);
      if (cnt[i] != '0) all_zero = 1'b0;
    end
  end

  // Round-robin search: first eligible client at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = TAG_W'(idx);
      end
    end
  end

  // One-hot grant; forced low while reset is asserted so every output reads 0.
  always_comb begin
    grant_vec = '0;
    if (grant_any && SoftReset_n) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.cl_rd_ready = grant_vec;
  assign accept          = |grant_vec;

  // Per-client credit increment (accept) and decrement (routed response).
  always_comb begin
    inc_vec = grant_vec;
    dec_vec = '0;
    if (rsp_hit) dec_vec[rsp_tag] = 1'b1;
  end

  // Round-robin pointer advances past the accepted client only.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  // Registered FIU request; address/mdata hold when nothing is accepted.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      bus.fiu_rd_valid <= 1'b0;
      bus.fiu_rd_addr  <= '0;
      bus.fiu_rd_mdata <= '0;
    end else begin
      bus.fiu_rd_valid <= accept;
      if (accept) begin
        bus.fiu_rd_addr  <= bus.cl_rd_addr[grant_idx*ADDR_W +: ADDR_W];
        bus.fiu_rd_mdata <= {grant_idx, bus.cl_rd_mdata[grant_idx*CL_MD_W +: CL_MD_W]};
      end
    end
  end

  // Registered response routing; mdata/data are shared and load on a routed response.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      bus.cl_rsp_valid <= '0;
      bus.cl_rsp_mdata <= '0;
      bus.cl_rsp_data  <= '0;
    end else begin
      bus.cl_rsp_valid <= dec_vec;
      if (rsp_hit) begin
        bus.cl_rsp_mdata <= bus.fiu_rsp_mdata[CL_MD_W-1:0];
        bus.cl_rsp_data  <= bus.fiu_rsp_data;
      end
    end
  end

  // Credit counters and sticky error (bad tag, or response with no credit out).
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < N_CLIENTS; i++) cnt[i] <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (bus.fiu_rsp_valid && !tag_ok) err_sticky <= 1'b1;
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] == '0) err_sticky <= 1'b1;
          else              cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) state <= RUN;
    else              state <= state_nxt;
  end

  // Drain FSM next state; a dropped drain_req wins over completion in DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)    state_nxt = RUN;
        else if (all_zero) state_nxt = DRAINED;
      end
      DRAINED: if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef CCIP_RD_MUX_STATS_EN
  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      stat_grants      <= '0;
      stat_almfull_cyc <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (inc_vec[i]) stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      end
      if ((|bus.cl_rd_valid) && bus.fiu_almfull) stat_almfull_cyc <= stat_almfull_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccip_rd_client_mux.sv
// Directed bench for ccip_rd_client_mux (N=4, MAX_OUT=32): round-robin order,
// almfull back-pressure, credit limit, response routing, underflow error,
// drain FSM and asynchronous reset mid-burst.
module tb_ccip_rd_client_mux;
  localparam int N       = 4;
  localparam int ADDR_W  = 42;
  localparam int MDATA_W = 16;
  localparam int DATA_W  = 512;
  localparam int CL_MD_W = 14;

  logic       pClk = 1'b0;
  logic       SoftReset_n;
  logic       drain_req;
  logic       drain_done;
  logic       err_sticky;
  logic [1:0] fsm_state;
`ifdef CCIP_RD_MUX_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_almfull_cyc;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  ccip_rd_client_mux_if #(.N_CLIENTS(N), .ADDR_W(ADDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W)) bus ();

  ccip_rd_client_mux #(
    .N_CLIENTS(N), .ADDR_W(ADDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W), .MAX_OUT(32)
  ) u_dut (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .bus         (bus),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .err_sticky  (err_sticky),
`ifdef CCIP_RD_MUX_STATS_EN
    .stat_grants      (stat_grants),
    .stat_almfull_cyc (stat_almfull_cyc),
`endif
    .fsm_state   (fsm_state)
  );

  // clock
  always #5 pClk = ~pClk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rsp(input logic [15:0] md, input logic [31:0] word);
    bus.fiu_rsp_valid = 1'b1;
    bus.fiu_rsp_mdata = md;
    bus.fiu_rsp_data  = {16{word}};
  endtask

  int tags [6] = '{0, 0, 1, 1, 2, 3};
  int g;

  initial begin
    // reset and idle inputs
    SoftReset_n       = 1'b0;
    drain_req         = 1'b0;
    bus.cl_rd_valid   = '0;
    bus.fiu_almfull   = 1'b0;
    bus.fiu_rsp_valid = 1'b0;
    bus.fiu_rsp_mdata = '0;
    bus.fiu_rsp_data  = '0;
    for (int i = 0; i < N; i++) begin
      bus.cl_rd_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(42'h100 + i);
      bus.cl_rd_mdata[i*CL_MD_W +: CL_MD_W] = CL_MD_W'(14'h10 + i);
    end
    repeat (2) @(negedge pClk);
    chk("rst_fiu_valid", bus.fiu_rd_valid, 0);
    chk("rst_fiu_addr", bus.fiu_rd_addr, 0);
    chk("rst_fiu_mdata", bus.fiu_rd_mdata, 0);
    chk("rst_rsp_valid", bus.cl_rsp_valid, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_err", err_sticky, 0);
    SoftReset_n = 1'b1;
    @(negedge pClk);

    // all clients valid: grants 0,1,2,3,0,1
    bus.cl_rd_valid = 4'hF;
    #1 chk("rr_first_ready", bus.cl_rd_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      @(negedge pClk);
      g = k % 4;
      chk("rr_fiu_valid", bus.fiu_rd_valid, 1);
      chk("rr_tag", bus.fiu_rd_mdata[15:14], g);
      chk("rr_mdata", bus.fiu_rd_mdata, (g << 14) | (16 + g));
      chk("rr_addr", bus.fiu_rd_addr, 'h100 + g);
      chk("rr_next_ready", bus.cl_rd_ready, 1 << ((g + 1) % 4));
    end
    bus.cl_rd_valid = '0;
    @(negedge pClk);
    chk("idle_fiu_valid", bus.fiu_rd_valid, 0);
    chk("hold_mdata", bus.fiu_rd_mdata, 16'h4011);
    chk("hold_addr", bus.fiu_rd_addr, 'h101);

    // return the six outstanding reads
    for (int j = 0; j < 6; j++) begin
      send_rsp(16'((tags[j] << 14) | (12'hA00 + j)), 32'(j + 1));
      @(negedge pClk);
      chk("rsp_valid", bus.cl_rsp_valid, 1 << tags[j]);
      chk("rsp_mdata", bus.cl_rsp_mdata, 'hA00 + j);
      chk("rsp_data_lo", bus.cl_rsp_data[31:0], j + 1);
      chk("rsp_data_hi", bus.cl_rsp_data[511:480], j + 1);
    end
    bus.fiu_rsp_valid = 1'b0;
    @(negedge pClk);
    chk("rsp_idle", bus.cl_rsp_valid, 0);
    chk("rsp_no_err", err_sticky, 0);

    // almfull for 5 cycles: no accepts, pointer stays at 2
    bus.cl_rd_valid = 4'hF;
    bus.fiu_almfull = 1'b1;
    #1 chk("af_ready", bus.cl_rd_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge pClk);
      chk("af_fiu_valid", bus.fiu_rd_valid, 0);
      chk("af_ready_hold", bus.cl_rd_ready, 0);
    end
    bus.fiu_almfull = 1'b0;
    #1 chk("af_ptr_kept", bus.cl_rd_ready, 4'b0100);
    bus.cl_rd_valid = '0;
    @(negedge pClk);
    chk("af_no_accept", bus.fiu_rd_valid, 0);

    // client 2 alone: 32 accepts then blocked
    bus.cl_rd_valid = 4'b0100;
    for (int k = 0; k < 32; k++) begin
      #1 chk("cr_ready", bus.cl_rd_ready, 4'b0100);
      @(negedge pClk);
    end
    #1 chk("cr_full", bus.cl_rd_ready, 0);
    chk("cr_last_valid", bus.fiu_rd_valid, 1);
    chk("cr_last_mdata", bus.fiu_rd_mdata, 16'h8012);
    @(negedge pClk);
    chk("cr_full_idle", bus.fiu_rd_valid, 0);
    chk("cr_full_ready", bus.cl_rd_ready, 0);
    send_rsp(16'h8005, 32'h55);
    #1 chk("cr_same_cycle", bus.cl_rd_ready, 0);
    @(negedge pClk);
    bus.fiu_rsp_valid = 1'b0;
    chk("cr_rsp_valid", bus.cl_rsp_valid, 4'b0100);
    #1 chk("cr_regrant", bus.cl_rd_ready, 4'b0100);
    @(negedge pClk);
    chk("cr_regrant_valid", bus.fiu_rd_valid, 1);
    #1 chk("cr_full_again", bus.cl_rd_ready, 0);
    bus.cl_rd_valid = '0;

    // return all 32 credits; the last one is 16'h8123
    for (int k = 0; k < 31; k++) begin
      send_rsp(16'h8000 | 16'(k), 32'(k));
      @(negedge pClk);
    end
    send_rsp(16'h8123, 32'hCAFE);
    @(negedge pClk);
    bus.fiu_rsp_valid = 1'b0;
    chk("t2_rsp_valid", bus.cl_rsp_valid, 4'b0100);
    chk("t2_rsp_mdata", bus.cl_rsp_mdata, 14'h0123);
    chk("t2_no_err", err_sticky, 0);
    // same response again with no credit outstanding
    send_rsp(16'h8123, 32'hBEEF);
    @(negedge pClk);
    bus.fiu_rsp_valid = 1'b0;
    chk("uf_delivered", bus.cl_rsp_valid, 4'b0100);
    chk("uf_err", err_sticky, 1);
    @(negedge pClk);
    chk("uf_idle", bus.cl_rsp_valid, 0);

    // drain: three reads outstanding (clients 3,0,1)
    bus.cl_rd_valid = 4'hF;
    #1 chk("dr_first_ready", bus.cl_rd_ready, 4'b1000);
    repeat (3) @(negedge pClk);
    bus.cl_rd_valid = '0;
    drain_req = 1'b1;
    chk("dr_last_tag", bus.fiu_rd_mdata[15:14], 1);
    @(negedge pClk);
    chk("dr_state", fsm_state, 2'd1);
    chk("dr_done_low", drain_done, 0);
    bus.cl_rd_valid = 4'hF;
    #1 chk("dr_no_grant", bus.cl_rd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      send_rsp(16'(((k == 0 ? 3 : k - 1) << 14) | k), 32'(k));
      @(negedge pClk);
      chk("dr_done_wait", drain_done, 0);
    end
    bus.fiu_rsp_valid = 1'b0;
    chk("dr_third_rsp", bus.cl_rsp_valid, 4'b0010);
    @(negedge pClk);
    chk("dr_done", drain_done, 1);
    chk("dr_drained_state", fsm_state, 2'd2);
    chk("dr_drained_ready", bus.cl_rd_ready, 0);
    drain_req = 1'b0;
    @(negedge pClk);
    chk("dr_run_done", drain_done, 0);
    #1 chk("dr_run_ready", bus.cl_rd_ready, 4'b0100);

    // burst, then asynchronous reset mid-burst
    repeat (2) @(negedge pClk);
    SoftReset_n = 1'b0;
    #1;
    chk("ar_ready", bus.cl_rd_ready, 0);
    chk("ar_fiu_valid", bus.fiu_rd_valid, 0);
    chk("ar_fiu_mdata", bus.fiu_rd_mdata, 0);
    chk("ar_fiu_addr", bus.fiu_rd_addr, 0);
    chk("ar_err", err_sticky, 0);
    chk("ar_drain_done", drain_done, 0);
    @(negedge pClk);
    SoftReset_n = 1'b1;
    #1 chk("ar_restart_ready", bus.cl_rd_ready, 4'b0001);
    @(negedge pClk);
    chk("ar_restart_valid", bus.fiu_rd_valid, 1);
    chk("ar_restart_tag", bus.fiu_rd_mdata[15:14], 0);
    bus.cl_rd_valid = '0;
    @(negedge pClk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
